// File: rtl/fifo_word_packer_if.sv
// Byte-FIFO read port, packed-word output stream and flush handshake of the word packer.
// master = the packer, slave = the FIFO/downstream side.
interface fifo_word_packer_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_LANES = 4,
    parameter int CNT_W     = $clog2(NUM_LANES + 1)
);
    logic                       fifo_empty;
    logic [WIDTH-1:0]           fifo_rdata;
    logic                       fifo_rd_en;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH*NUM_LANES-1:0] out_data;
    logic [CNT_W-1:0]           out_lanes;
    logic                       flush;
    logic                       flush_done;

    modport master (
        input  fifo_empty, fifo_rdata, out_ready, flush,
        output fifo_rd_en, out_valid, out_data, out_lanes, flush_done
    );

    modport slave (
        output fifo_empty, fifo_rdata, out_ready, flush,
        input  fifo_rd_en, out_valid, out_data, out_lanes, flush_done
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops entries from a synchronous FIFO and packs NUM_LANES of them little-endian into
// one wide word on a valid/ready stream; flush emits a zero-padded partial word.
//
// state   | meaning
// S_RUN   | normal packing; a flush request is handled from here
// S_PULSE | partial word just loaded, flush_done pulses next
// S_WAIT  | flush finished, waiting for the requester to drop flush
module fifo_word_packer #(
    parameter int  WIDTH     = 8,
    parameter int  NUM_LANES = 4,
    localparam int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic               clk,
    input  logic               res,
    fifo_word_packer_if.master bus
);
    localparam int               WORD_W   = WIDTH * NUM_LANES;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_LANES);
    localparam logic [CNT_W:0]   FULL_EXT = (CNT_W + 1)'(NUM_LANES);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PULSE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    out_lanes_q, out_lanes_d;
    logic                out_valid_q, out_valid_d;
    logic                flush_done_q, flush_done_d;

    logic                out_free;
    logic                xfer_full;
    logic                xfer_part;
    logic                xfer;
    logic                room;
    logic                pop;
    logic [CNT_W:0]      fill;
    logic [CNT_W-1:0]    base_cnt;

    // Datapath: pop decision, byte capture and accumulator-to-output transfer.
    always_comb begin
        out_free  = !out_valid_q || bus.out_ready;
        xfer_full = (cnt_q == FULL_CNT) && out_free;
        xfer_part = (state_q == S_RUN) && bus.flush && !pend_q &&
                    (cnt_q != '0) && (cnt_q != FULL_CNT) && out_free;
        xfer      = xfer_full || xfer_part;

        // Entries in flight count against capacity so the accumulator never overruns.
        fill = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
        room = (fill < FULL_EXT);
        pop  = !bus.fifo_empty && !bus.flush && (room || xfer);

        // Clearing on transfer keeps unused lanes zero for partial words.
        base_cnt = xfer ? '0 : cnt_q;
        acc_d    = xfer ? '0 : acc_q;
        cnt_d    = base_cnt;
        if (pend_q) begin
            acc_d[int'(base_cnt)*WIDTH +: WIDTH] = bus.fifo_rdata;
            cnt_d = base_cnt + CNT_W'(1);
        end
        pend_d = pop;

        out_data_d  = out_data_q;
        out_lanes_d = out_lanes_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (xfer) begin
            out_data_d  = acc_q;
            out_lanes_d = cnt_q;
            out_valid_d = 1'b1;
        end
    end

    // Flush sequencing.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (bus.flush && !pend_q) begin
                    if (cnt_q == '0) begin
                        flush_done_d = 1'b1;
                        state_d      = S_WAIT;
                    end else if (xfer_part) begin
                        state_d = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                flush_done_d = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.flush) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= S_RUN;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_lanes_q  <= '0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_lanes_q  <= out_lanes_d;
            out_valid_q  <= out_valid_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Pop is gated by the reset level so the FIFO sees no request while held in reset.
    assign bus.fifo_rd_en = pop && res;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_lanes  = out_lanes_q;
    assign bus.flush_done = flush_done_q;
endmodule
